// File: rtl/caravel.sv
// Byte-to-word packer: collects groups of four input bytes and emits two packed
// words plus a 10-bit byte sum per group, with partial-group flush on in_last.
module caravel (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready
);

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] EMIT0   = 2'd1;
    localparam logic [1:0] EMIT1   = 2'd2;
    localparam logic [1:0] EMIT2   = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic [1:0]  cnt_reg;
    logic [7:0]  byte_reg [4];
    logic        last_reg;
    logic        in_ready_reg;
    logic [15:0] out_data_reg;
    logic        out_valid_reg;
    logic        out_last_reg;

    logic        in_fire;
    logic        out_fire;
    logic        closing;
    logic [7:0]  group_byte [4];
    logic [9:0]  byte_sum;

    assign in_fire  = in_valid && in_ready_reg;
    assign out_fire = out_valid_reg && out_ready;
    assign closing  = in_fire && (in_last || (cnt_reg == 2'd3));

    // Slots above the counter are still zero here, which gives the partial-group
    // flush its 0x00 padding for free.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_group
            assign group_byte[gi] = (cnt_reg == 2'(gi)) ? in_data : byte_reg[gi];
        end
    endgenerate

    assign byte_sum = {2'b00, byte_reg[0]} + {2'b00, byte_reg[1]}
                    + {2'b00, byte_reg[2]} + {2'b00, byte_reg[3]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (closing)  state_next = EMIT0;
            EMIT0:   if (out_fire) state_next = EMIT1;
            EMIT1:   if (out_fire) state_next = EMIT2;
            EMIT2:   if (out_fire) state_next = COLLECT;
            default:               state_next = COLLECT;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg     <= COLLECT;
            cnt_reg       <= 2'd0;
            last_reg      <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_data_reg  <= 16'h0000;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            for (int i = 0; i < 4; i++) byte_reg[i] <= 8'h00;
        end else begin
            state_reg    <= state_next;
            // Registered so the producer sees ready exactly when COLLECT resumes.
            in_ready_reg <= (state_next == COLLECT);
            case (state_reg)
                COLLECT: begin
                    if (closing) begin
                        for (int i = 0; i < 4; i++) byte_reg[i] <= group_byte[i];
                        last_reg      <= in_last;
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= {group_byte[1], group_byte[0]};
                        out_last_reg  <= 1'b0;
                    end else if (in_fire) begin
                        byte_reg[cnt_reg] <= in_data;
                        cnt_reg           <= cnt_reg + 2'd1;
                    end
                end
                EMIT0: begin
                    if (out_fire) out_data_reg <= {byte_reg[3], byte_reg[2]};
                end
                EMIT1: begin
                    if (out_fire) begin
                        out_data_reg <= {6'b000000, byte_sum};
                        out_last_reg <= last_reg;
                    end
                end
                EMIT2: begin
                    if (out_fire) begin
                        out_valid_reg <= 1'b0;
                        out_data_reg  <= 16'h0000;
                        out_last_reg  <= 1'b0;
                        last_reg      <= 1'b0;
                        cnt_reg       <= 2'd0;
                        for (int i = 0; i < 4; i++) byte_reg[i] <= 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_caravel.sv
// Bench for caravel: directed scenarios plus a randomized 2048-byte frame,
// all words cross-checked against a byte-group reference model.
module tb_caravel;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [7:0]  in_data  = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last  = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b0;

    int vectors    = 0;
    int miscompares = 0;

    logic [16:0] exp_q [$];
    logic [16:0] log_q [$];
    logic [7:0]  grp_q [$];
    logic        hold_valid = 1'b0;
    logic [15:0] hold_data;
    logic        hold_last;

    caravel dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Reference model: bytes grouped in fours (zero padded on in_last), each group
    // expanding to {b1,b0}, {b3,b2}, b0+b1+b2+b3. Everything sampled mid-cycle.
    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            exp_q.delete();
            grp_q.delete();
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                vectors++;
                if (!out_valid || out_data !== hold_data || out_last !== hold_last) begin
                    miscompares++;
                    $display("FAIL hold_stable: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             out_valid, out_data, out_last, hold_data, hold_last);
                end
            end
            hold_valid = 1'b0;
            if (out_valid && out_ready) begin
                vectors++;
                log_q.push_back({out_last, out_data});
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word: got %h last=%b, required no word", out_data, out_last);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    if ({out_last, out_data} !== e) begin
                        miscompares++;
                        $display("FAIL word: got %h last=%b, required %h last=%b",
                                 out_data, out_last, e[15:0], e[16]);
                    end
                end
            end else if (out_valid) begin
                hold_valid = 1'b1;
                hold_data  = out_data;
                hold_last  = out_last;
            end
            if (in_valid && in_ready) begin
                grp_q.push_back(in_data);
                if (in_last || grp_q.size() == 4) begin
                    int s;
                    while (grp_q.size() < 4) grp_q.push_back(8'h00);
                    s = grp_q[0] + grp_q[1] + grp_q[2] + grp_q[3];
                    exp_q.push_back({1'b0, grp_q[1], grp_q[0]});
                    exp_q.push_back({1'b0, grp_q[3], grp_q[2]});
                    exp_q.push_back({in_last, 16'(s)});
                    grp_q.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Holds in_valid high until the byte is accepted; in_valid left asserted.
    task automatic send_byte(input logic [7:0] d, input logic l);
        logic acc;
        acc = 1'b0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge wb_clk_i);
            acc = in_ready;
            tick();
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got in_ready stuck 0, required acceptance of %h", d);
        end
    endtask

    task automatic check_word(input string name, input logic [15:0] d, input logic l);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== d || out_last !== l) begin
            miscompares++;
            $display("FAIL %s: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                     name, out_valid, out_data, out_last, d, l);
        end
    endtask

    task automatic check_idle(input string name);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: got out_valid=%b in_ready=%b, required out_valid=0 in_ready=1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (3) tick();
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_last !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b data=%h last=%b in_ready=%b, required 0 0000 0 0",
                     out_valid, out_data, out_last, in_ready);
        end
        wb_rst_i = 1'b0;
        tick();
        check_idle("reset_release");
    endtask

    task automatic run_group(input string name, input logic [7:0] b [4], input int n, input logic l,
                             input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) send_byte(b[i], (i == n - 1) ? l : 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_word({name, "_w0"}, w0, 1'b0);
        tick();
        check_word({name, "_w1"}, w1, 1'b0);
        tick();
        check_word({name, "_w2"}, w2, l);
        tick();
        check_idle({name, "_after"});
    endtask

    task automatic test_basic();
        logic [7:0] b [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_group("basic", b, 4, 1'b0, 16'h0201, 16'h0403, 16'h000A);
    endtask

    task automatic test_max_last();
        logic [7:0] b [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_group("max_last", b, 4, 1'b1, 16'hFFFF, 16'hFFFF, 16'h03FC);
    endtask

    task automatic test_partial();
        logic [7:0] b [4] = '{8'hAA, 8'h55, 8'h00, 8'h00};
        run_group("partial", b, 2, 1'b1, 16'h55AA, 16'h0000, 16'h00FF);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [4];
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
            run_group("b2b", b, 4, 1'b0, {b[1], b[0]}, {b[3], b[2]},
                      16'(b[0] + b[1] + b[2] + b[3]));
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 1'b0);
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 16'h0201 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_hold: got valid=%b data=%h in_ready=%b, required 1 0201 0",
                         out_valid, out_data, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        check_word("bp_w0", 16'h0201, 1'b0);
        tick();
        check_word("bp_w1", 16'h0403, 1'b0);
        tick();
        check_word("bp_w2", 16'h000A, 1'b0);
        tick();
        check_idle("bp_after");
    endtask

    task automatic test_reset_mid();
        logic [7:0] b [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_word("rst_mid_emit1", 16'h0403, 1'b0);
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_mid_clear: got valid=%b data=%h, required 0 0000", out_valid, out_data);
        end
        tick();
        check_idle("rst_mid_ready");
        run_group("rst_mid_fresh", b, 4, 1'b0, 16'h0201, 16'h0403, 16'h000A);
    endtask

    task automatic test_frame();
        bit stop;
        int nlast, last_idx, n;
        stop = 1'b0;
        log_q.delete();
        fork
            begin
                for (int i = 0; i < 2048; i++) begin
                    logic acc;
                    acc = 1'b0;
                    in_data = 8'(i);
                    in_last = (i == 2047);
                    for (int t = 0; t < 500 && !acc; t++) begin
                        in_valid = ($urandom_range(0, 3) != 0);
                        @(negedge wb_clk_i);
                        acc = in_valid && in_ready;
                        tick();
                    end
                    if (!acc) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL frame_send_timeout: byte %0d not accepted, required acceptance", i);
                        break;
                    end
                end
                in_valid = 1'b0;
                in_last  = 1'b0;
                n = 0;
                while (log_q.size() < 1536 && n < 5000) begin
                    tick();
                    n++;
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        repeat (10) tick();
        vectors++;
        if (log_q.size() != 1536) begin
            miscompares++;
            $display("FAIL frame_count: got %0d words, required 1536", log_q.size());
        end
        if (log_q.size() >= 3) begin
            vectors++;
            if (log_q[0] !== 17'h00100 || log_q[1] !== 17'h00302 || log_q[2] !== 17'h00006) begin
                miscompares++;
                $display("FAIL frame_first_group: got %h %h %h, required 00100 00302 00006",
                         log_q[0], log_q[1], log_q[2]);
            end
        end
        nlast = 0;
        last_idx = -1;
        for (int i = 0; i < log_q.size(); i++)
            if (log_q[i][16]) begin
                nlast++;
                last_idx = i;
            end
        vectors++;
        if (nlast != 1 || last_idx != 1535 || log_q[1535] !== 17'h103F6) begin
            miscompares++;
            $display("FAIL frame_last: got %0d last flags at index %0d, required 1 at 1535 with 03F6",
                     nlast, last_idx);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_last();
        test_partial();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_frame();
        repeat (5) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL model_drain: got %0d words still expected, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/caravel.md
CARAVEL -- requirements
Module: caravel

Interface
REQ-001 Parameters: none; frame length is set by in_last, not by configuration.
REQ-002 wb_clk_i  input  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-003 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-004 in_data  input  8  input stream byte.
REQ-005 in_valid  input  1  input byte present.
REQ-006 in_last  input  1  qualifies the final byte of a frame.
REQ-007 in_ready  output  1  block can accept a byte this cycle.
REQ-008 out_data  output  16  output stream word.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_last  output  1  qualifies the final word of a frame.
REQ-011 out_ready  input  1  downstream accepts a word this cycle.

Function
REQ-012 Input transfer SHALL occur only on a rising edge where in_valid=1 and in_ready=1; output transfer SHALL occur only where out_valid=1 and out_ready=1.
REQ-013 Input bytes SHALL be grouped in fours, b0..b3 in arrival order; each group SHALL produce exactly three output words, in this order:
- W0 = {b1, b0}
- W1 = {b3, b2}
- W2 = zero-extended 10-bit unsigned sum b0+b1+b2+b3.
REQ-014 A 2048-byte frame SHALL therefore yield 1536 words.
REQ-015 FSM states:
- COLLECT: byte counter 0..3; in_ready=1.
- EMIT0, EMIT1, EMIT2: in_ready=0.
REQ-016 COLLECT SHALL go to EMIT0 on acceptance of the 4th byte, or on acceptance of any byte carrying in_last.
REQ-017 EMITn SHALL advance to the next state (EMIT2 to COLLECT, counter cleared) only on an output transfer; otherwise it SHALL hold.
REQ-018 When in_last arrives before the 4th byte, the missing bytes SHALL be treated as 0x00 (partial-group flush).
REQ-019 out_last SHALL be 1 only with W2 of a group that was closed by in_last; it SHALL be 0 on all other words.
REQ-020 out_data, out_valid and out_last SHALL be registered.
REQ-021 out_valid SHALL rise on the edge that accepts the closing byte, so W0 is valid in the next cycle (latency 1 cycle).
REQ-022 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-023 out_valid SHALL never drop without a transfer.
REQ-024 With out_ready held at 1, the three words SHALL appear on three consecutive cycles, and in_ready SHALL return to 1 in the cycle after W2 transfers.
REQ-025 in_valid=0 cycles inside a group SHALL neither advance the counter nor alter stored bytes.
REQ-026 in_data SHALL be ignored whenever in_ready=0.
REQ-027 The sum SHALL NOT overflow (maximum 0x03FC); out_data[15:10] of W2 SHALL be 0.

Reset
REQ-028 While wb_rst_i=1 at a rising edge, the block SHALL set: state COLLECT, byte counter 0, stored bytes 0, out_valid=0, out_last=0, out_data=0x0000, in_ready=0.
REQ-029 in_ready SHALL become 1 in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-group or mid-emission SHALL discard all pending data; no word from before reset SHALL be emitted afterwards.

Verification
REQ-031 Bytes 01,02,03,04 back-to-back, out_ready=1 -> words 0201, 0403, 000A on consecutive cycles; out_last=0 throughout.
REQ-032 Bytes FF,FF,FF,FF with in_last on the 4th -> FFFF, FFFF, 03FC; out_last=1 only on 03FC.
REQ-033 Bytes AA,55 with in_last on 55 -> 55AA, 0000, 00FF; out_last=1 on 00FF; in_ready=1 afterwards.
REQ-034 out_ready=0 for 5 cycles while W0=0201 is valid -> out_valid=1, out_data=0201 stable, in_ready=0; the sequence resumes unchanged when out_ready=1.
REQ-035 2048 bytes, value i mod 256, random in_valid, random out_ready, in_last on byte 2047 -> exactly 1536 words.
- Each group matches REQ-013 (first group: 0100, 0302, 0006).
- out_last asserted only on word 1535, whose value is 03F6.
REQ-036 Reset pulse during EMIT1 -> next cycle out_valid=0 and out_data=0000, then in_ready=1; a fresh group 01,02,03,04 yields 0201, 0403, 000A.
